// File: rtl/axi_arp_rx.sv
// axi_arp_rx: receive-side ARP parser.
// Consumes the byte stream that follows the Ethernet header and validates the
// 28-byte ARP body. A well-formed packet is held on the arp_* outputs until
// the responder acknowledges it. Short, malformed or non-ARP frames are
// counted in a saturating drop counter.
// Optional feature: define AXI_ARP_RX_IP_FILTER_EN to drop frames whose target
// IP differs from {IP_MSB, IP_LSB}.
module axi_arp_rx #(
  parameter logic [15:0] IP_MSB = 16'hc0a8,
  parameter logic [15:0] IP_LSB = 16'h0602
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [15:0] eth_ethertype,
  input  logic [7:0]  eth_axis_tdata,
  input  logic        eth_axis_tvalid,
  input  logic        eth_axis_tlast,
  output logic        eth_axis_tready,
  output logic        arp_req,
  input  logic        arp_ack,
  output logic [15:0] arp_opcode,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic [47:0] arp_dst_mac,
  output logic [31:0] arp_dst_ip,
  output logic [15:0] arp_drop_cnt
);

  localparam logic [1:0] S_RECV  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [7:0] LAST_IDX = 8'd27;

  logic [1:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        tready_q;
  logic        req_q;
  logic [15:0] drop_q;
  logic        drop_inc;
  logic        beat;
  logic        byte_bad;
  logic        err_now;
  logic [15:0] opcode_q;
  logic [47:0] src_mac_q;
  logic [31:0] src_ip_q;
  logic [47:0] dst_mac_q;
  logic [31:0] dst_ip_q;

  assign beat    = eth_axis_tvalid && tready_q;
  assign err_now = err_q || byte_bad;

  // Per-byte header check for the body byte currently on the bus.
  always_comb begin
    byte_bad = 1'b0;
    if (state_q == S_RECV) begin
      case (idx_q)
        8'd0: byte_bad = (eth_axis_tdata != 8'h00) || (eth_ethertype != 16'h0806);
        8'd1: byte_bad = (eth_axis_tdata != 8'h01);
        8'd2: byte_bad = (eth_axis_tdata != 8'h08);
        8'd3: byte_bad = (eth_axis_tdata != 8'h00);
        8'd4: byte_bad = (eth_axis_tdata != 8'd6);
        8'd5: byte_bad = (eth_axis_tdata != 8'd4);
        8'd6: byte_bad = (eth_axis_tdata != 8'h00);
        8'd7: byte_bad = !((eth_axis_tdata == 8'h01) || (eth_axis_tdata == 8'h02));
`ifdef AXI_ARP_RX_IP_FILTER_EN
        // The first three target-IP bytes are already shifted into dst_ip_q.
        8'd27: byte_bad = ({dst_ip_q[23:0], eth_axis_tdata} != {IP_MSB, IP_LSB});
`endif
        default: byte_bad = 1'b0;
      endcase
    end
  end

  // Frame sequencing: receive body, drain padding, hold for the responder.
  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    drop_inc = 1'b0;
    case (state_q)
      S_RECV: begin
        if (beat) begin
          if (eth_axis_tlast) begin
            if ((idx_q == LAST_IDX) && !err_now) begin
              state_d = S_HOLD;
            end else begin
              drop_inc = 1'b1;
              idx_d    = 8'd0;
              err_d    = 1'b0;
            end
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN;
            err_d   = err_now;
          end else begin
            idx_d = idx_q + 8'd1;
            err_d = err_now;
          end
        end
      end
      S_DRAIN: begin
        if (beat && eth_axis_tlast) begin
          if (!err_q) begin
            state_d = S_HOLD;
          end else begin
            state_d  = S_RECV;
            drop_inc = 1'b1;
            idx_d    = 8'd0;
            err_d    = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (arp_ack) begin
          state_d = S_RECV;
          idx_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_RECV;
    endcase
  end

  // State, handshake flags and drop counter.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_RECV;
      idx_q    <= 8'd0;
      err_q    <= 1'b0;
      tready_q <= 1'b0;
      req_q    <= 1'b0;
      drop_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      tready_q <= (state_d != S_HOLD);
      req_q    <= (state_d == S_HOLD);
      if (drop_inc && (drop_q != 16'hffff)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Capture body fields big-endian as bytes arrive; frozen while holding.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      opcode_q  <= 16'd0;
      src_mac_q <= 48'd0;
      src_ip_q  <= 32'd0;
      dst_mac_q <= 48'd0;
      dst_ip_q  <= 32'd0;
    end else if (beat && (state_q == S_RECV)) begin
      if (idx_q >= 8'd6 && idx_q <= 8'd7) begin
        opcode_q <= {opcode_q[7:0], eth_axis_tdata};
      end else if (idx_q >= 8'd8 && idx_q <= 8'd13) begin
        src_mac_q <= {src_mac_q[39:0], eth_axis_tdata};
      end else if (idx_q >= 8'd14 && idx_q <= 8'd17) begin
        src_ip_q <= {src_ip_q[23:0], eth_axis_tdata};
      end else if (idx_q >= 8'd18 && idx_q <= 8'd23) begin
        dst_mac_q <= {dst_mac_q[39:0], eth_axis_tdata};
      end else if (idx_q >= 8'd24 && idx_q <= 8'd27) begin
        dst_ip_q <= {dst_ip_q[23:0], eth_axis_tdata};
      end
    end
  end

  assign eth_axis_tready = tready_q;
  assign arp_req         = req_q;
  assign arp_opcode      = opcode_q;
  assign arp_src_mac     = src_mac_q;
  assign arp_src_ip      = src_ip_q;
  assign arp_dst_mac     = dst_mac_q;
  assign arp_dst_ip      = dst_ip_q;
  assign arp_drop_cnt    = drop_q;

endmodule

// File: tb/tb_axi_arp_rx.sv
// Bench for axi_arp_rx: directed frames, a frame-level reference model
// (expected packet queue plus drop count) checked every cycle, and literal
// expectations for the documented scenarios.
module tb_axi_arp_rx;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [15:0] eth_ethertype;
  logic [7:0]  eth_axis_tdata;
  logic        eth_axis_tvalid;
  logic        eth_axis_tlast;
  logic        eth_axis_tready;
  logic        arp_req;
  logic        arp_ack;
  logic [15:0] arp_opcode;
  logic [47:0] arp_src_mac;
  logic [31:0] arp_src_ip;
  logic [47:0] arp_dst_mac;
  logic [31:0] arp_dst_ip;
  logic [15:0] arp_drop_cnt;

  always #5 clk = ~clk;

  axi_arp_rx dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .eth_ethertype  (eth_ethertype),
    .eth_axis_tdata (eth_axis_tdata),
    .eth_axis_tvalid(eth_axis_tvalid),
    .eth_axis_tlast (eth_axis_tlast),
    .eth_axis_tready(eth_axis_tready),
    .arp_req        (arp_req),
    .arp_ack        (arp_ack),
    .arp_opcode     (arp_opcode),
    .arp_src_mac    (arp_src_mac),
    .arp_src_ip     (arp_src_ip),
    .arp_dst_mac    (arp_dst_mac),
    .arp_dst_ip     (arp_dst_ip),
    .arp_drop_cnt   (arp_drop_cnt)
  );

  typedef struct packed {
    logic [15:0] op;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [47:0] dmac;
    logic [31:0] dip;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [15:0] exp_drop = 16'd0;
  logic [7:0]  frame_buf [0:63];
  int          n_pass = 0;
  int          n_total = 0;
  bit          tr_valid = 1'b0;
  bit          ack_always = 1'b0;
  int          ack_delay = 3;
  int          hold_cnt = 0;
  bit          pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame-level rules: length, ethertype, fixed header fields, opcode, filter.
  function automatic bit model_ok(input logic [15:0] et, input int len, output pkt_t p);
    bit ok;
    p.op = {frame_buf[6], frame_buf[7]};
    p.smac = '0; p.sip = '0; p.dmac = '0; p.dip = '0;
    for (int k = 0; k < 6; k++) p.smac = {p.smac[39:0], frame_buf[8 + k]};
    for (int k = 0; k < 4; k++) p.sip  = {p.sip[23:0],  frame_buf[14 + k]};
    for (int k = 0; k < 6; k++) p.dmac = {p.dmac[39:0], frame_buf[18 + k]};
    for (int k = 0; k < 4; k++) p.dip  = {p.dip[23:0],  frame_buf[24 + k]};
    ok = (len >= 28) && (et == 16'h0806)
      && ({frame_buf[0], frame_buf[1]} == 16'h0001)
      && ({frame_buf[2], frame_buf[3]} == 16'h0800)
      && (frame_buf[4] == 8'd6) && (frame_buf[5] == 8'd4)
      && ((p.op == 16'd1) || (p.op == 16'd2));
`ifdef AXI_ARP_RX_IP_FILTER_EN
    if (p.dip != 32'hc0a80602) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic build(input logic [15:0] op, input logic [47:0] smac, input logic [31:0] sip,
                       input logic [47:0] dmac, input logic [31:0] dip);
    logic [223:0] body;
    body = {16'h0001, 16'h0800, 8'd6, 8'd4, op, smac, sip, dmac, dip};
    for (int k = 0; k < 64; k++) frame_buf[k] = 8'h00;
    for (int k = 0; k < 28; k++) frame_buf[k] = body[223 - 8*k -: 8];
  endtask

  task automatic do_reset();
    tr_valid = 1'b0;
    aresetn = 1'b0;
    eth_axis_tvalid = 1'b0;
    eth_axis_tlast = 1'b0;
    exp_q.delete();
    exp_drop = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_tready", eth_axis_tready, 1'b0);
    check("rst_req", arp_req, 1'b0);
    check("rst_drop", arp_drop_cnt, 16'd0);
    check("rst_opcode", arp_opcode, 16'd0);
    check("rst_src_mac", arp_src_mac, 48'd0);
    check("rst_dst_ip", arp_dst_ip, 32'd0);
    aresetn = 1'b1;
    @(posedge clk);
    tr_valid = 1'b1;
    @(negedge clk);
    check("rst_tready_release", eth_axis_tready, 1'b1);
  endtask

  // Drives frame_buf[0:len-1]; returns on the negedge after the tlast beat.
  task automatic send_frame(input logic [15:0] et, input int len, input int gap_every, input int abort_at);
    pkt_t p;
    int   wait_c;
    eth_ethertype = et;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        do_reset();
        return;
      end
      if (gap_every > 0 && (i % gap_every) == gap_every - 1) begin
        eth_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      eth_axis_tvalid = 1'b1;
      eth_axis_tdata  = frame_buf[i];
      eth_axis_tlast  = (i == len - 1);
      wait_c = 0;
      while (!eth_axis_tready) begin
        if (wait_c == 200) begin
          n_total++;
          $display("FAIL beat_timeout: tready low 200 cycles at byte %0d, required high", i);
          eth_axis_tvalid = 1'b0;
          eth_axis_tlast  = 1'b0;
          return;
        end
        wait_c++;
        @(negedge clk);
      end
      @(posedge clk);
    end
    if (model_ok(et, len, p)) exp_q.push_back(p);
    else if (exp_drop != 16'hffff) exp_drop = exp_drop + 16'd1;
    @(negedge clk);
    eth_axis_tvalid = 1'b0;
    eth_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && (exp_q.size() != 0 || arp_req); c++) @(negedge clk);
    if (exp_q.size() != 0 || arp_req) begin
      n_total++;
      $display("FAIL idle_timeout: arp_req=%0b pending=%0d, required idle", arp_req, exp_q.size());
    end
    @(negedge clk);
  endtask

  // Responder: ack after ack_delay cycles in hold, or permanently when ack_always.
  initial begin
    arp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_always) begin
        arp_ack = 1'b1;
      end else if (arp_req && aresetn) begin
        hold_cnt++;
        arp_ack = (hold_cnt >= ack_delay);
        if (arp_ack) hold_cnt = 0;
      end else begin
        arp_ack = 1'b0;
        hold_cnt = 0;
      end
      pend = arp_ack && arp_req && aresetn;
      @(posedge clk);
      if (pend && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // Per-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    if (tr_valid) begin
      check("req", arp_req, exp_q.size() != 0);
      check("tready", eth_axis_tready, exp_q.size() == 0);
      check("drop_cnt", arp_drop_cnt, exp_drop);
      if (arp_req && exp_q.size() != 0) begin
        check("opcode", arp_opcode, exp_q[0].op);
        check("src_mac", arp_src_mac, exp_q[0].smac);
        check("src_ip", arp_src_ip, exp_q[0].sip);
        check("dst_mac", arp_dst_mac, exp_q[0].dmac);
        check("dst_ip", arp_dst_ip, exp_q[0].dip);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    eth_ethertype = 16'h0806;
    eth_axis_tdata = 8'h00;
    eth_axis_tvalid = 1'b0;
    eth_axis_tlast = 1'b0;
    do_reset();

    // Plain request, tlast on byte 27.
    ack_delay = 3;
    build(16'h0001, 48'h020000000001, 32'hc0a80601, 48'h0, 32'hc0a80602);
    send_frame(16'h0806, 28, 0, -1);
    check("t1_req", arp_req, 1'b1);
    check("t1_opcode", arp_opcode, 16'h0001);
    check("t1_src_mac", arp_src_mac, 48'h020000000001);
    check("t1_src_ip", arp_src_ip, 32'hc0a80601);
    check("t1_dst_mac", arp_dst_mac, 48'h0);
    check("t1_dst_ip", arp_dst_ip, 32'hc0a80602);
    wait_idle();
    check("t1_req_clear", arp_req, 1'b0);

    // Same packet padded to 46 bytes, with tvalid gaps.
    send_frame(16'h0806, 46, 7, -1);
    check("t2_req", arp_req, 1'b1);
    check("t2_src_ip", arp_src_ip, 32'hc0a80601);
    check("t2_drop", arp_drop_cnt, 16'd0);
    wait_idle();

    // Short, bad hw type, bad ethertype, bad opcode.
    send_frame(16'h0806, 21, 0, -1);
    check("t3_drop1", arp_drop_cnt, 16'd1);
    frame_buf[1] = 8'h06;
    send_frame(16'h0806, 28, 0, -1);
    check("t3_drop2", arp_drop_cnt, 16'd2);
    frame_buf[1] = 8'h01;
    send_frame(16'h0800, 28, 0, -1);
    check("t3_drop3", arp_drop_cnt, 16'd3);
    frame_buf[7] = 8'h03;
    send_frame(16'h0806, 30, 0, -1);
    check("t3_drop4", arp_drop_cnt, 16'd4);
    check("t3_no_req", arp_req, 1'b0);

    // Back-to-back frames with a slow responder.
    ack_delay = 10;
    build(16'h0001, 48'h020000000001, 32'hc0a80601, 48'h0, 32'hc0a80602);
    send_frame(16'h0806, 28, 0, -1);
    build(16'h0002, 48'h020000000002, 32'hc0a80605, 48'h020000000001, 32'hc0a80602);
    send_frame(16'h0806, 28, 0, -1);
    check("t4_req", arp_req, 1'b1);
    check("t4_opcode", arp_opcode, 16'h0002);
    check("t4_src_ip", arp_src_ip, 32'hc0a80605);
    wait_idle();

    // Target IP filter.
    ack_delay = 2;
    build(16'h0001, 48'h020000000007, 32'hc0a80607, 48'h0, 32'hc0a80603);
    send_frame(16'h0806, 28, 0, -1);
`ifdef AXI_ARP_RX_IP_FILTER_EN
    check("t5_filtered_drop", arp_drop_cnt, 16'd5);
    check("t5_filtered_req", arp_req, 1'b0);
`else
    check("t5_unfiltered_req", arp_req, 1'b1);
    check("t5_unfiltered_dst", arp_dst_ip, 32'hc0a80603);
`endif
    wait_idle();
    build(16'h0001, 48'h020000000007, 32'hc0a80607, 48'h0, 32'hc0a80602);
    send_frame(16'h0806, 28, 0, -1);
    check("t5_local_req", arp_req, 1'b1);
    wait_idle();

    // Ack held high: each packet released after one cycle in hold.
    ack_always = 1'b1;
    send_frame(16'h0806, 28, 0, -1);
    check("t6_req_rise", arp_req, 1'b1);
    @(negedge clk);
    check("t6_req_one_cycle", arp_req, 1'b0);
    send_frame(16'h0806, 28, 0, -1);
    check("t6_req_rise2", arp_req, 1'b1);
    wait_idle();
    ack_always = 1'b0;
    ack_delay = 3;

    // Reset at byte 12, then a clean frame.
    build(16'h0001, 48'h020000000009, 32'hc0a80609, 48'h0, 32'hc0a80602);
    send_frame(16'h0806, 28, 0, 12);
    check("t7_drop_after_rst", arp_drop_cnt, 16'd0);
    check("t7_no_req", arp_req, 1'b0);
    send_frame(16'h0806, 28, 0, -1);
    check("t7_req", arp_req, 1'b1);
    check("t7_src_mac", arp_src_mac, 48'h020000000009);
    check("t7_src_ip", arp_src_ip, 32'hc0a80609);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
